fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; state forced while reset=0.
REQ-004 stall  input  1  downstream (IF_ID enable low) hold; 1 = current F-stage outputs not consumed this edge.
REQ-005 redirect  input  1  control-flow change (branch/jump taken); also kills F-stage contents.
REQ-006 redirect_pc  input  32  target address, sampled when redirect=1.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  32  word-aligned read address; stable while imem_req=1 until imem_rvalid.
REQ-009 imem_rvalid  input  1  one-cycle response strobe; only while imem_req=1.
REQ-010 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-011 InstrF  output  32  fetched instruction to IF_ID.
REQ-012 PCF  output  32  address of InstrF.
REQ-013 PCPlus4F  output  32  PCF+4, modulo 2^32.
REQ-014 ValidF  output  1  InstrF/PCF/PCPlus4F hold a live instruction.

Function
REQ-015 Storage: output buffer (InstrF/PCF/PCPlus4F/ValidF), one pending entry (instr, pc, valid), next-fetch PC (pc_q), request address (addr_q).
REQ-016 Consumption: buffer consumed at an edge where ValidF=1 and stall=0.
REQ-017 At most one memory request outstanding; imem_req held high, imem_addr unchanged, until imem_rvalid.
REQ-018 States: REQ (imem_req=1, addr=addr_q), BLOCK (imem_req=0), DISCARD (imem_req=1, addr=addr_q, response dropped).
REQ-019 REQ on imem_rvalid, no redirect: response routed per REQ-021; pc_q and addr_q <= addr_q+4; next state BLOCK if pending becomes valid, else REQ.
REQ-020 BLOCK -> REQ on the edge pending drains into buffer.
REQ-021 Routing of a response at an edge: buffer if buffer empty or being consumed (and pending empty); else pending.
REQ-022 On consumption: buffer <= pending if pending valid (pending cleared), else response if present, else ValidF <= 0.
REQ-023 PCPlus4F always equals PCF+4; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-024 Redirect priority over stall and rvalid: ValidF<=0, pending cleared, pc_q<=redirect_pc.
REQ-025 Redirect in REQ without same-cycle rvalid: -> DISCARD, addr_q unchanged; on its rvalid, response dropped, addr_q<=pc_q, -> REQ.
REQ-026 Redirect with same-cycle rvalid, or in BLOCK: response (if any) dropped, addr_q<=redirect_pc, -> REQ.
REQ-027 Redirect in DISCARD: pc_q updated to newest redirect_pc; stays DISCARD until rvalid.
REQ-028 No instruction delivered twice or skipped; program order preserved in ValidF stream.
REQ-029 Best-case throughput: one instruction per cycle with zero-wait memory and stall=0.

Reset
REQ-030 reset=0: ValidF=0, InstrF=PCF=PCPlus4F=0, pending cleared, pc_q=addr_q=RESET_PC, state REQ, immediately, independent of clock.
REQ-031 First cycle after reset release: imem_req=1, imem_addr=RESET_PC.
REQ-032 Reset during outstanding request: request abandoned; memory model must tolerate req dropping.

Verification
REQ-033 Zero-wait memory, stall=0: ValidF=1 with PCF=0,4,8,... on consecutive cycles; PCPlus4F=PCF+4.
REQ-034 stall=1 for 3 cycles after PCF=8 delivered: PCF holds 8, pending holds 12, imem_req=0; release -> 12 then 16, none lost.
REQ-035 3-wait memory, redirect to 0x100 one cycle after req for 0x10: stale 0x10 response dropped, next ValidF has PCF=0x100.
REQ-036 redirect=1 with stall=1 and imem_rvalid=1 same cycle: ValidF=0 next cycle, pending empty, imem_addr=redirect_pc.
REQ-037 redirect_pc=32'hFFFF_FFFC: PCPlus4F=0, following fetch address 0.
REQ-038 reset=0 asserted mid-stall with ValidF=1: outputs zero asynchronously; after release imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, a one-entry pending slot
// and an output buffer feeding IF_ID; redirects kill in-flight work and retarget fetch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        ValidF
);

    typedef enum logic [1:0] {StReq, StBlock, StDiscard} state_e;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic [31:0] pend_instr_q, pend_instr_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;

    logic consume;
    logic resp;
    logic buf_take_resp;

    assign consume       = valid_q && !stall;
    assign resp          = (state_q == StReq) && imem_rvalid;
    // A response may only bypass into the buffer when nothing older is queued ahead of it.
    assign buf_take_resp = resp && !pend_valid_q && (!valid_q || consume);

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        pcf_d        = pcf_q;
        pcp4_d       = pcp4_q;
        valid_d      = valid_q;
        pend_instr_d = pend_instr_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        pc_d         = pc_q;
        addr_d       = addr_q;

        if (redirect) begin
            valid_d      = 1'b0;
            pend_valid_d = 1'b0;
            pc_d         = redirect_pc;
            // An unanswered request must still be waited out; its data is dropped later.
            if (state_q != StBlock && !imem_rvalid) begin
                state_d = StDiscard;
            end else begin
                addr_d  = redirect_pc;
                state_d = StReq;
            end
        end else begin
            if (consume && pend_valid_q) begin
                instr_d      = pend_instr_q;
                pcf_d        = pend_pc_q;
                pcp4_d       = pend_pc_q + 32'd4;
                valid_d      = 1'b1;
                pend_valid_d = 1'b0;
            end else if (buf_take_resp) begin
                instr_d = imem_rdata;
                pcf_d   = addr_q;
                pcp4_d  = addr_q + 32'd4;
                valid_d = 1'b1;
            end else if (consume) begin
                valid_d = 1'b0;
            end

            if (resp && !buf_take_resp) begin
                pend_instr_d = imem_rdata;
                pend_pc_d    = addr_q;
                pend_valid_d = 1'b1;
            end

            unique case (state_q)
                StReq: begin
                    if (imem_rvalid) begin
                        pc_d    = addr_q + 32'd4;
                        addr_d  = addr_q + 32'd4;
                        state_d = pend_valid_d ? StBlock : StReq;
                    end
                end
                StBlock: begin
                    if (consume && pend_valid_q) begin
                        state_d = StReq;
                    end
                end
                StDiscard: begin
                    if (imem_rvalid) begin
                        addr_d  = pc_q;
                        state_d = StReq;
                    end
                end
                default: state_d = StReq;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StReq;
            instr_q      <= 32'h0;
            pcf_q        <= 32'h0;
            pcp4_q       <= 32'h0;
            valid_q      <= 1'b0;
            pend_instr_q <= 32'h0;
            pend_pc_q    <= 32'h0;
            pend_valid_q <= 1'b0;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            pcf_q        <= pcf_d;
            pcp4_q       <= pcp4_d;
            valid_q      <= valid_d;
            pend_instr_q <= pend_instr_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
        end
    end

    assign imem_req  = (state_q != StBlock);
    assign imem_addr = addr_q;
    assign InstrF    = instr_q;
    assign PCF       = pcf_q;
    assign PCPlus4F  = pcp4_q;
    assign ValidF    = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a wait-state-configurable instruction memory model.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        ValidF;

    int errors = 0;
    int checks = 0;
    int waits  = 0;
    int wcnt;

    fetch_stage dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrF      (InstrF),
        .PCF         (PCF),
        .PCPlus4F    (PCPlus4F),
        .ValidF      (ValidF)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory answers after `waits` idle cycles; data word is the address xor a tag.
    always_comb begin
        imem_rvalid = imem_req && (wcnt >= waits);
        imem_rdata  = imem_rvalid ? (imem_addr ^ 32'hDEAD_0000) : 32'h0;
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) wcnt <= 0;
        else if (imem_req && !imem_rvalid) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!ValidF && n < max) begin
            step();
            n++;
        end
        check("wait_valid", {31'h0, ValidF}, 32'h1);
    endtask

    initial begin
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #12;
        check("rst_valid", {31'h0, ValidF}, 32'h0);
        check("rst_instr", InstrF, 32'h0);
        check("rst_pcf", PCF, 32'h0);
        check("rst_pcp4", PCPlus4F, 32'h0);
        step();
        reset = 1'b1;

        // First cycle after release: request RESET_PC.
        check("first_req", {31'h0, imem_req}, 32'h1);
        check("first_addr", imem_addr, 32'h0);

        // Zero-wait streaming: 0, 4, 8 on consecutive cycles.
        step();
        check("s0_valid", {31'h0, ValidF}, 32'h1);
        check("s0_pcf", PCF, 32'h0);
        check("s0_pcp4", PCPlus4F, 32'h4);
        check("s0_instr", InstrF, 32'hDEAD_0000);
        step();
        check("s1_pcf", PCF, 32'h4);
        step();
        check("s2_pcf", PCF, 32'h8);
        check("s2_instr", InstrF, 32'hDEAD_0008);

        // Stall three cycles with PCF=8 held.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pcf", PCF, 32'h8);
            check("stall_valid", {31'h0, ValidF}, 32'h1);
            check("stall_req", {31'h0, imem_req}, 32'h0);
        end
        stall = 1'b0;
        step();
        check("rel_pcf12", PCF, 32'hC);
        check("rel_instr12", InstrF, 32'hDEAD_000C);
        check("rel_req", {31'h0, imem_req}, 32'h1);
        check("rel_addr", imem_addr, 32'h10);
        step();
        check("rel_pcf16", PCF, 32'h10);

        // Redirect with stall and rvalid in the same cycle.
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        stall    = 1'b0;
        redirect = 1'b0;
        check("rs_valid", {31'h0, ValidF}, 32'h0);
        check("rs_addr", imem_addr, 32'h200);
        check("rs_req", {31'h0, imem_req}, 32'h1);
        step();
        check("rs_pcf", PCF, 32'h200);
        check("rs_pcp4", PCPlus4F, 32'h204);
        step();
        check("rs_next", PCF, 32'h204);

        // Redirect to 0x10, then to 0x100 while the 0x10 request waits.
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        step();
        redirect = 1'b0;
        waits    = 3;
        check("w_addr10", imem_addr, 32'h10);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        check("d_valid", {31'h0, ValidF}, 32'h0);
        check("d_addr_hold", imem_addr, 32'h10);
        check("d_req", {31'h0, imem_req}, 32'h1);
        step();
        step();
        check("d_dropped", {31'h0, ValidF}, 32'h0);
        check("d_addr100", imem_addr, 32'h100);
        wait_valid(10);
        check("d_pcf", PCF, 32'h100);
        check("d_instr", InstrF, 32'hDEAD_0100);

        // Wrap-around at the top of the address space.
        waits       = 0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        check("wr_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wr_valid", {31'h0, ValidF}, 32'h1);
        check("wr_pcf", PCF, 32'hFFFF_FFFC);
        check("wr_pcp4", PCPlus4F, 32'h0);
        check("wr_next_addr", imem_addr, 32'h0);

        // Asynchronous reset in the middle of a stall.
        stall = 1'b1;
        step();
        step();
        check("ar_pre_valid", {31'h0, ValidF}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_valid", {31'h0, ValidF}, 32'h0);
        check("ar_pcf", PCF, 32'h0);
        check("ar_pcp4", PCPlus4F, 32'h0);
        check("ar_instr", InstrF, 32'h0);
        step();
        reset = 1'b1;
        stall = 1'b0;
        check("ar_addr", imem_addr, 32'h0);
        check("ar_req", {31'h0, imem_req}, 32'h1);
        step();
        check("ar_pcf0", PCF, 32'h0);
        check("ar_valid0", {31'h0, ValidF}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
